sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count and sticky overflow/underflow error flags.
- Same w_en/r_en/data_in/data_out/full/empty contract as the team's asynchronous FIFO, so existing interface and testbench components carry over.
- Used for intra-clock-domain buffering between producer and consumer blocks.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 8, number of entries; power of two, >= 4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  clock; all logic on rising edge
rstn  in  1  asynchronous active-low reset
w_en  in  1  write request
r_en  in  1  read request
data_in  in  DATA_WIDTH  write data
err_clr  in  1  synchronous clear of overflow/underflow
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rstn low, asynchronous): pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits. Address = low bits; MSB is the wrap bit. Wrap from DEPTH-1 to 0 is natural binary rollover.
- Write accept: wr_ok = w_en && !full. Stores data_in at wr_ptr; wr_ptr+1.
- Read accept: rd_ok = r_en && !empty. data_out <= mem[rd_ptr] on the same edge (1-cycle latency); rd_ptr+1. data_out holds its value when there is no read.
- Blocking is evaluated on registered flags only. A write while full is rejected even if r_en is high that cycle. A read while empty is rejected even if w_en is high.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. count never exceeds DEPTH or goes below 0.
- All flags are registered and derived from next-state count, so they are valid in the cycle after the accepting edge.
- overflow set on w_en && full. underflow set on r_en && empty. Both stay set until err_clr or reset. If err_clr and a new error occur in the same cycle, set wins.
- Rejected operations leave pointers, memory, count and data_out unchanged.
- Reset asserted mid-operation: immediate return to reset state. Data in flight is discarded.
- No state machine beyond pointer/count registers.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally whenever !empty; 0 when empty.
  - r_en with !empty pops the entry, and the next word appears in the same cycle as the pointer update.
  - Read latency is 0.
- Undefined: registered 1-cycle read as above.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - localparam functions for ADDR_W=$clog2(DEPTH) and CNT_W=ADDR_W+1.
  - typedef for pointer struct {wrap bit, addr}.
  - Enum for error bit positions (ERR_OVF=0, ERR_UDF=1).
- Sub-module fifo_mem:
  - Simple dual-port register array: one write port, one read port with asynchronous read address.
  - Instantiated once; all control logic stays in sync_fifo_flags.

Test Plan:
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
- Reset: hold rstn=0 for 3 clocks, then release -> empty=1, almost_empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
- Fill: write 0x10..0x17 on 8 consecutive clocks -> almost_empty drops after count=3; almost_full rises at count=6; full=1 at count=8. A 9th write of 0xAA -> overflow=1, count stays 8, 0xAA is never read.
- Drain: 8 reads after fill -> data_out sequence 0x10..0x17 (1 cycle after each r_en; same cycle under FIFO_FWFT_EN), empty=1. A 9th read -> underflow=1 and data_out holds 0x17 (non-FWFT).
- Wrap and simultaneous: pre-load 4 words, then 20 cycles of w_en=r_en=1 with incrementing data -> count stays 4 and output order is preserved across pointer wrap. Simultaneous w_en+r_en while full -> write rejected, count=7.
- Error clear: after overflow, pulse err_clr -> overflow=0. err_clr coincident with w_en while full -> overflow stays 1.
- Mid-operation reset: drop rstn asynchronously (not on an edge) with count=5 -> all outputs at reset values immediately. After release, first read data equals the first post-reset write.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and error-bit encoding for the single-clock flagged FIFO.
// No logic, so no latency.
// No flow control lives here.
package fifo_pkg;

    // Address width of a power-of-two FIFO with the given depth
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer and occupancy width: one extra bit so "full" and "empty" are distinct
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Number of sticky error bits
    localparam int ERR_W = 2;

    // Bit positions inside the sticky error register
    typedef enum logic [0:0] {
        ERR_OVF = 1'b0,
        ERR_UDF = 1'b1
    } err_bit_e;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read data follows raddr combinationally.
// No backpressure; the caller decides when to write. Contents are not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; no reset so the array maps onto plain flops or LUT RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Read latency 1 cycle (registered data_out); 0 cycles when FIFO_FWFT_EN is defined (first-word-fall-through).
// Writes blocked while full, reads blocked while empty (registered flags only); blocked attempts set sticky errors.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      w_en,
    input  logic                      r_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      err_clr,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    // Pointer = wrap bit above the array address; the wrap bit lets the
    // plain difference of two pointers give occupancy 0..DEPTH.
    typedef struct packed {
        logic              wrap;
        logic [ADDR_W-1:0] addr;
    } ptr_t;

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t wr_ptr_nxt;
    ptr_t rd_ptr_nxt;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [CNT_W-1:0]      count_nxt;
    logic [ERR_W-1:0]      err_q;
    logic [ERR_W-1:0]      err_nxt;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Accept decisions use only the registered flags, so a read in the same
    // cycle never frees room for a write while full (and vice versa).
    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    assign wr_ptr_nxt = wr_ok ? ptr_t'(CNT_W'(wr_ptr) + CNT_W'(1)) : wr_ptr;
    assign rd_ptr_nxt = rd_ok ? ptr_t'(CNT_W'(rd_ptr) + CNT_W'(1)) : rd_ptr;

    // Occupancy is the pointer distance; it is a pure function of registers,
    // and the next-state version feeds the registered flags.
    assign count     = CNT_W'(wr_ptr)     - CNT_W'(rd_ptr);
    assign count_nxt = CNT_W'(wr_ptr_nxt) - CNT_W'(rd_ptr_nxt);

    // Pointer registers advance only on accepted operations
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Status flags registered from next-state occupancy so they are glitch-free
    // and valid the cycle after the accepting edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (count_nxt == CNT_W'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_W'(AF_THRESH));
            almost_empty <= (count_nxt <= CNT_W'(AE_THRESH));
        end
    end

    // Sticky error next state: clear first, then a fresh error overrides the clear
    always_comb begin
        err_nxt = err_clr ? '0 : err_q;
        if (w_en && full) begin
            err_nxt[ERR_OVF] = 1'b1;
        end
        if (r_en && empty) begin
            err_nxt[ERR_UDF] = 1'b1;
        end
    end

    // Sticky error register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= '0;
        end else begin
            err_q <= err_nxt;
        end
    end

    assign overflow  = err_q[ERR_OVF];
    assign underflow = err_q[ERR_UDF];

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr.addr),
        .wdata (data_in),
        .raddr (rd_ptr.addr),
        .rdata (mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    // Head of queue is always visible; forced to zero when nothing is stored
    assign data_out = empty ? '0 : mem_rdata;
`else
    // Registered read: capture the head on an accepted read, hold otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= mem_rdata;
        end
    end
`endif

endmodule : sync_fifo_flags

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic          err_clr;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int total  = 0;
    int passed = 0;

    // Reference model / scoreboard
    logic [DW-1:0] sb_q [$];
    int            m_count;
    logic          m_ovf;
    logic          m_udf;
    logic [DW-1:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_dout  = '0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".count"},     32'(count),        32'(m_count));
        chk({ph, ".full"},      32'(full),         32'(m_count == DEPTH));
        chk({ph, ".empty"},     32'(empty),        32'(m_count == 0));
        chk({ph, ".afull"},     32'(almost_full),  32'(m_count >= AF));
        chk({ph, ".aempty"},    32'(almost_empty), 32'(m_count <= AE));
        chk({ph, ".overflow"},  32'(overflow),     32'(m_ovf));
        chk({ph, ".underflow"}, 32'(underflow),    32'(m_udf));
        chk({ph, ".data_out"},  32'(data_out),     32'(m_dout));
    endtask

    // One clock of stimulus; model updates at the edge, DUT checked 1 time unit later
    task automatic step(input string ph, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic clr);
        logic          mw;
        logic          mr;
        logic [DW-1:0] popped;
        w_en    = w;
        r_en    = r;
        data_in = d;
        err_clr = clr;
        @(posedge clk);
        mw = w && (m_count != DEPTH);
        mr = r && (m_count != 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && m_count == DEPTH) m_ovf = 1'b1;
        if (r && m_count == 0)     m_udf = 1'b1;
        if (mr) begin
            popped = sb_q.pop_front();
`ifndef FIFO_FWFT_EN
            m_dout = popped;
`endif
        end
        if (mw) sb_q.push_back(d);
        m_count = sb_q.size();
`ifdef FIFO_FWFT_EN
        m_dout = (sb_q.size() != 0) ? sb_q[0] : '0;
`endif
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        err_clr = 1'b0;
        check_all(ph);
    endtask

    initial begin
        rstn    = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        err_clr = 1'b0;
        model_reset();

        // Reset held for 3 clocks, then released
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_all("reset");

        // Fill 0x10..0x17, then a rejected 9th write
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        step("fill_ovf", 1'b1, 1'b0, 8'hAA, 1'b0);

        // Drain all eight, then a rejected 9th read
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        step("drain_udf", 1'b0, 1'b1, 8'h00, 1'b0);

        // Clear errors
        step("errclr", 1'b0, 1'b0, 8'h00, 1'b1);

        // Fill again, then err_clr coincident with a write while full
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        step("clr_vs_ovf", 1'b1, 1'b0, 8'hBB, 1'b1);
        step("errclr2", 1'b0, 1'b0, 8'h00, 1'b1);

        // Drain to four entries, then twenty simultaneous read/write cycles across the wrap
        for (int i = 0; i < 4; i++) step("predrain", 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);

        // Top up to full, then simultaneous read/write while full
        for (int i = 0; i < 4; i++) step("topup", 1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        step("full_rw", 1'b1, 1'b1, 8'hCC, 1'b0);

        // Down to five entries, then asynchronous reset away from any edge
        for (int i = 0; i < 2; i++) step("to5", 1'b0, 1'b1, 8'h00, 1'b0);
        chk("pre_rst.count", 32'(count), 32'd5);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        // First read after reset returns the first post-reset write
        step("pr_wr", 1'b1, 1'b0, 8'h5A, 1'b0);
        step("pr_wr2", 1'b1, 1'b0, 8'h5B, 1'b0);
        step("pr_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        chk("pr_first", 32'(data_out), 32'h5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_sync_fifo_flags
